pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; all other ports are listed below (name, direction, width, meaning).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ID_rs, ID_rt  input  5 each  source registers of the instruction in ID.
REQ-005 ID_halt  input  1  halt opcode decoded in ID.
REQ-006 ID_EX_MemRead, ID_EX_rt  input  1, 5  load flag and destination register of the instruction in EX.
REQ-007 EX_MEM_PCSrc  input  1  taken branch or jump resolved in MEM.
REQ-008 imem_ready  input  1  instruction memory returns valid data this cycle.
REQ-009 PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush  output  1 each  pipeline register controls.
REQ-010 halted  output  1  pipeline is drained and stopped.
REQ-011 imem_timeout  output  1  sticky instruction-memory timeout flag.
REQ-012 stall_cycles, flush_count  output  16 each  saturating performance counters.

Function
REQ-013 The block SHALL implement FSM states RUN, DRAIN and HALTED; control outputs are combinational from state and inputs; counters and flags are registered.
REQ-014 hazard SHALL be defined as ID_EX_MemRead && ID_EX_rt!=0 && (ID_EX_rt==ID_rs || ID_EX_rt==ID_rt).
REQ-015 Per-cycle priority SHALL be: redirect (EX_MEM_PCSrc) > hazard > fetch wait (!imem_ready) > ID_halt > normal.
REQ-016 Redirect, in RUN or DRAIN: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=ID_EX_Flush=EX_MEM_Flush=1; next state RUN; drain counter cleared.
REQ-017 Hazard (RUN, no redirect): PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, other flushes=0.
REQ-018 Fetch wait (RUN, no redirect, no hazard): PCWrite=0, IF_ID_Write=1, IF_ID_Flush=1.
REQ-019 Normal (RUN): PCWrite=1, IF_ID_Write=1, all flushes=0.
REQ-020 ID_halt in RUN with no higher-priority event: PCWrite=0, IF_ID_Write=0, no flush; next state DRAIN; 2-bit drain counter loaded with 3.
REQ-021 DRAIN without redirect: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; counter decrements each cycle; at counter==1 the next state SHALL be HALTED (3 DRAIN cycles).
REQ-022 HALTED: all control outputs 0, halted=1; EX_MEM_PCSrc is ignored; exit only by reset.
REQ-023 stall_cycles SHALL increment, saturating at 0xFFFF, on every cycle in RUN where PCWrite=0 due to hazard or fetch wait.
REQ-024 flush_count SHALL increment, saturating at 0xFFFF, on every redirect cycle.
REQ-025 A 4-bit wait counter SHALL count consecutive RUN cycles with imem_ready=0 and clear on imem_ready=1; when it reaches 15 while imem_ready is still 0 (the 16th consecutive cycle), imem_timeout SHALL set and stay set until reset.
REQ-026 When redirect and hazard occur in the same cycle, the redirect response SHALL apply and the stall counter SHALL NOT increment.

Reset
REQ-027 While rst=1: state=RUN, drain and wait counters=0, stall_cycles=0, flush_count=0, halted=0, imem_timeout=0; control outputs follow RUN decode.
REQ-028 Reset asserted mid-DRAIN or in HALTED SHALL return the block to RUN immediately, without waiting for a clock edge.

Verification
REQ-029 ID_EX_MemRead=1, ID_EX_rt=5, ID_rs=5 for 1 cycle -> PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; stall_cycles 0->1.
REQ-030 ID_EX_rt=0 with ID_rs=0 and MemRead=1 -> no stall; PCWrite=1.
REQ-031 Hazard and EX_MEM_PCSrc in the same cycle -> all three flushes=1, PCWrite=1; flush_count=1, stall_cycles=0.
REQ-032 ID_halt pulse -> DRAIN for 3 cycles with ID_EX_Flush=1, then halted=1; a later EX_MEM_PCSrc has no effect.
REQ-033 ID_halt, then EX_MEM_PCSrc in the 2nd DRAIN cycle -> flushes asserted, back to RUN, halted stays 0.
REQ-034 imem_ready=0 for 16 cycles -> imem_timeout=1 on the 16th cycle and remains 1 after imem_ready returns; imem_ready=0 for 15 cycles -> imem_timeout stays 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard controller signal bundle.
// Decode/hazard inputs plus pipeline register controls and status.
interface pipe_hazard_ctrl_if;
   logic [4:0]  ID_rs;
   logic [4:0]  ID_rt;
   logic        ID_halt;
   logic        ID_EX_MemRead;
   logic [4:0]  ID_EX_rt;
   logic        EX_MEM_PCSrc;
   logic        imem_ready;
   logic        PCWrite;
   logic        IF_ID_Write;
   logic        IF_ID_Flush;
   logic        ID_EX_Flush;
   logic        EX_MEM_Flush;
   logic        halted;
   logic        imem_timeout;
   logic [15:0] stall_cycles;
   logic [15:0] flush_count;

   modport master (
      output ID_rs, ID_rt, ID_halt, ID_EX_MemRead, ID_EX_rt,
      output EX_MEM_PCSrc, imem_ready,
      input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
      input  EX_MEM_Flush, halted, imem_timeout,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  ID_rs, ID_rt, ID_halt, ID_EX_MemRead, ID_EX_rt,
      input  EX_MEM_PCSrc, imem_ready,
      output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
      output EX_MEM_Flush, halted, imem_timeout,
      output stall_cycles, flush_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, redirect flush,
// fetch wait, halt drain, perf counters and imem timeout.
module pipe_hazard_ctrl (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz
);
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} st_e;

   st_e         state, nxt;
   logic [1:0]  drain_cnt, drain_nxt;
   logic [3:0]  wait_cnt;
   logic [15:0] stall_q, flush_q;
   logic        tmo_q;
   logic        hazard;
   logic        stall_inc;
   logic        redir;

   assign hazard = hz.ID_EX_MemRead && (hz.ID_EX_rt != 5'd0) &&
                   ((hz.ID_EX_rt == hz.ID_rs) ||
                    (hz.ID_EX_rt == hz.ID_rt));

   always_comb begin
      nxt             = state;
      drain_nxt       = drain_cnt;
      stall_inc       = 1'b0;
      redir           = 1'b0;
      hz.PCWrite      = 1'b0;
      hz.IF_ID_Write  = 1'b0;
      hz.IF_ID_Flush  = 1'b0;
      hz.ID_EX_Flush  = 1'b0;
      hz.EX_MEM_Flush = 1'b0;
      unique case (state)
         RUN: begin
            if (hz.EX_MEM_PCSrc) begin
               redir = 1'b1;
            end else if (hazard) begin
               hz.ID_EX_Flush = 1'b1;
               stall_inc      = 1'b1;
            end else if (!hz.imem_ready) begin
               hz.IF_ID_Write = 1'b1;
               hz.IF_ID_Flush = 1'b1;
               stall_inc      = 1'b1;
            end else if (hz.ID_halt) begin
               nxt       = DRAIN;
               drain_nxt = 2'd3;
            end else begin
               hz.PCWrite     = 1'b1;
               hz.IF_ID_Write = 1'b1;
            end
         end
         DRAIN: begin
            if (hz.EX_MEM_PCSrc) begin
               redir = 1'b1;
            end else begin
               hz.ID_EX_Flush = 1'b1;
               drain_nxt      = drain_cnt - 2'd1;
               if (drain_cnt == 2'd1) nxt = HALTED;
            end
         end
         default: ;
      endcase
      // redirect wins everywhere except HALTED
      if (redir) begin
         nxt             = RUN;
         drain_nxt       = 2'd0;
         hz.PCWrite      = 1'b1;
         hz.IF_ID_Write  = 1'b1;
         hz.IF_ID_Flush  = 1'b1;
         hz.ID_EX_Flush  = 1'b1;
         hz.EX_MEM_Flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= RUN;
         drain_cnt <= 2'd0;
         wait_cnt  <= 4'd0;
         stall_q   <= 16'd0;
         flush_q   <= 16'd0;
         tmo_q     <= 1'b0;
      end else begin
         state     <= nxt;
         drain_cnt <= drain_nxt;
         if (stall_inc && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
         if (redir && flush_q != 16'hFFFF)
            flush_q <= flush_q + 16'd1;
         if (state == RUN && !hz.imem_ready) begin
            if (wait_cnt == 4'd15) tmo_q <= 1'b1;
            else                   wait_cnt <= wait_cnt + 4'd1;
         end else begin
            wait_cnt <= 4'd0;
         end
      end
   end

   assign hz.halted       = (state == HALTED);
   assign hz.imem_timeout = tmo_q;
   assign hz.stall_cycles = stall_q;
   assign hz.flush_count  = flush_q;
endmodule
